// File: rtl/l2_mem_axi_bridge_if.sv
// AXI4 field types and the single-beat AXI4 channel bundle
// used between the L2 memory bridge and its slave.
package axi_pkg;
   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  strb_t;
   typedef logic [7:0]  len_t;
   typedef logic [2:0]  size_t;
   typedef logic [1:0]  burst_t;
   typedef logic [1:0]  resp_t;

   localparam burst_t BURST_INCR = 2'b01;
   localparam resp_t  RESP_OKAY  = 2'b00;
   localparam size_t  SIZE_WORD  = 3'b010;
endpackage

interface axi_if;
   import axi_pkg::*;

   addr_t  araddr;
   len_t   arlen;
   size_t  arsize;
   burst_t arburst;
   logic   arvalid;
   logic   arready;

   data_t  rdata;
   resp_t  rresp;
   logic   rlast;
   logic   rvalid;
   logic   rready;

   addr_t  awaddr;
   len_t   awlen;
   size_t  awsize;
   burst_t awburst;
   logic   awvalid;
   logic   awready;

   data_t  wdata;
   strb_t  wstrb;
   logic   wlast;
   logic   wvalid;
   logic   wready;

   resp_t  bresp;
   logic   bvalid;
   logic   bready;

   modport master (
      output araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready,
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready,
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/l2_mem_axi_bridge.sv
// L2 memory port to AXI4 bridge: one single-beat transaction
// outstanding, one-cycle completion pulse, saturating error count.
module l2_mem_axi_bridge
   import axi_pkg::*;
#(
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_req_valid,
   input  logic [31:0]          mem_req_addr,
   input  logic                 mem_req_op,
   input  logic [31:0]          mem_write_data,
   output logic                 mem_resp_valid,
   output logic [31:0]          mem_resp_data,
   output logic                 mem_resp_err,
   output logic [ERR_CNT_W-1:0] err_count,
   axi_if.master                axi
);

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_D,
      WR_AW,
      WR_B,
      RESP
   } state_t;

   state_t state;
   addr_t  addr_q;
   data_t  wdata_q;
   logic   arvalid;
   logic   rready;
   logic   awvalid;
   logic   wvalid;
   logic   bready;
   logic   aw_done;
   logic   w_done;
   logic   aw_hs;
   logic   w_hs;
   logic   unused_addr_lsb;

   assign unused_addr_lsb = ^mem_req_addr[1:0];

   assign aw_hs = awvalid & axi.awready;
   assign w_hs  = wvalid & axi.wready;

   assign axi.araddr  = addr_q;
   assign axi.arlen   = '0;
   assign axi.arsize  = SIZE_WORD;
   assign axi.arburst = BURST_INCR;
   assign axi.arvalid = arvalid;
   assign axi.rready  = rready;

   assign axi.awaddr  = addr_q;
   assign axi.awlen   = '0;
   assign axi.awsize  = SIZE_WORD;
   assign axi.awburst = BURST_INCR;
   assign axi.awvalid = awvalid;

   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = 4'hF;
   assign axi.wlast   = 1'b1;
   assign axi.wvalid  = wvalid;
   assign axi.bready  = bready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         addr_q         <= '0;
         wdata_q        <= '0;
         arvalid        <= 1'b0;
         rready         <= 1'b0;
         awvalid        <= 1'b0;
         wvalid         <= 1'b0;
         bready         <= 1'b0;
         aw_done        <= 1'b0;
         w_done         <= 1'b0;
         mem_resp_valid <= 1'b0;
         mem_resp_data  <= '0;
         mem_resp_err   <= 1'b0;
         err_count      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (mem_req_valid) begin
                  addr_q  <= {mem_req_addr[31:2], 2'b00};
                  wdata_q <= mem_write_data;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  if (mem_req_op) begin
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     state   <= WR_AW;
                  end else begin
                     arvalid <= 1'b1;
                     state   <= RD_A;
                  end
               end
            end
            RD_A: begin
               if (axi.arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= RD_D;
               end
            end
            RD_D: begin
               if (axi.rvalid) begin
                  rready         <= 1'b0;
                  mem_resp_valid <= 1'b1;
                  mem_resp_data  <= axi.rdata;
                  mem_resp_err   <= (axi.rresp != RESP_OKAY) | ~axi.rlast;
                  state          <= RESP;
               end
            end
            WR_AW: begin
               // AW and W complete independently; either order or together
               if (aw_hs) begin
                  awvalid <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_hs) begin
                  wvalid <= 1'b0;
                  w_done <= 1'b1;
               end
               if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                  bready <= 1'b1;
                  state  <= WR_B;
               end
            end
            WR_B: begin
               if (axi.bvalid) begin
                  bready         <= 1'b0;
                  mem_resp_valid <= 1'b1;
                  mem_resp_data  <= '0;
                  mem_resp_err   <= (axi.bresp != RESP_OKAY);
                  state          <= RESP;
               end
            end
            RESP: begin
               mem_resp_valid <= 1'b0;
               if (mem_resp_err && (err_count != '1)) begin
                  err_count <= err_count + ERR_CNT_W'(1);
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_mem_axi_bridge.sv
// Randomized bench for l2_mem_axi_bridge: behavioural AXI slave,
// latency/data/error reference model, narrow error counter.
module tb_l2_mem_axi_bridge;
   import axi_pkg::*;

   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mem_req_valid = 1'b0;
   logic [31:0]   mem_req_addr = '0;
   logic          mem_req_op = 1'b0;
   logic [31:0]   mem_write_data = '0;
   logic          mem_resp_valid;
   logic [31:0]   mem_resp_data;
   logic          mem_resp_err;
   logic [CW-1:0] err_count;

   axi_if axi();

   l2_mem_axi_bridge #(.ERR_CNT_W(CW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_op     (mem_req_op),
      .mem_write_data (mem_write_data),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .err_count      (err_count),
      .axi            (axi)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int exp_cnt = 0;
   logic [31:0] mem [logic [29:0]];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] slave_rd(input logic [31:0] a);
      if (mem.exists(a[31:2])) return mem[a[31:2]];
      return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic slave_idle();
      axi.arready = 1'b0;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.rvalid  = 1'b0;
      axi.bvalid  = 1'b0;
      axi.rdata   = $urandom;
      axi.rresp   = 2'($urandom_range(0, 3));
      axi.rlast   = 1'($urandom_range(0, 1));
      axi.bresp   = 2'($urandom_range(0, 3));
   endtask

   // Called at #1 after an edge in an IDLE cycle; returns likewise.
   task automatic txn(input bit op, input logic [31:0] addr,
                      input logic [31:0] wd, input int ar_w,
                      input int aw_w, input int w_w, input int d_w,
                      input logic [1:0] resp, input bit last,
                      input bit keep);
      int cyc = 0;
      int ar_n = 0;
      int aw_n = 0;
      int w_n = 0;
      int d_n = 0;
      int lat;
      bit ar_ok = 0;
      bit aw_ok = 0;
      bit w_ok = 0;
      bit wa_done = 0;
      bit done = 0;
      bit exp_err;
      logic [31:0] word;
      logic [31:0] exp_data;
      word = {addr[31:2], 2'b00};
      lat = op ? 3 + ((aw_w > w_w) ? aw_w : w_w) + d_w
               : 3 + ar_w + d_w;
      exp_data = op ? 32'h0 : slave_rd(word);
      exp_err = (resp != 2'b00) || (!op && !last);
      chk("idle_quiet",
          {29'h0, axi.arvalid, axi.awvalid, axi.wvalid}, 32'h0);
      mem_req_valid  = 1'b1;
      mem_req_op     = op;
      mem_req_addr   = addr;
      mem_write_data = wd;
      while (!done && cyc < 64) begin
         @(posedge clk);
         #1;
         cyc++;
         mem_req_addr   = $urandom;
         mem_write_data = $urandom;
         slave_idle();
         if (mem_resp_valid) begin
            done = 1;
            chk("latency", cyc, lat);
            chk("resp_data", mem_resp_data, exp_data);
            chk("resp_err", {31'h0, mem_resp_err}, {31'h0, exp_err});
            if (op && resp == 2'b00) mem[word[31:2]] = wd;
            if (exp_err && exp_cnt != CMAX) exp_cnt++;
            if (!keep) mem_req_valid = 1'b0;
         end else if (!op) begin
            axi.bvalid = 1'($urandom_range(0, 1));
            chk("rd_no_wr",
                {29'h0, axi.awvalid, axi.wvalid, axi.bready}, 32'h0);
            if (!ar_ok) begin
               chk("arvalid", {31'h0, axi.arvalid}, 32'h1);
               if (ar_n == 0) begin
                  chk("araddr", axi.araddr, word);
                  chk("arlen", {24'h0, axi.arlen}, 32'h0);
                  chk("arsize", {29'h0, axi.arsize}, 32'h2);
                  chk("arburst", {30'h0, axi.arburst}, 32'h1);
               end
               if (ar_n >= ar_w) begin
                  axi.arready = 1'b1;
                  ar_ok = 1;
               end
               ar_n++;
            end else begin
               chk("ar_drop", {31'h0, axi.arvalid}, 32'h0);
               chk("rready", {31'h0, axi.rready}, 32'h1);
               if (d_n >= d_w) begin
                  axi.rvalid = 1'b1;
                  axi.rdata  = slave_rd(word);
                  axi.rresp  = resp;
                  axi.rlast  = last;
               end
               d_n++;
            end
         end else begin
            axi.rvalid = 1'($urandom_range(0, 1));
            chk("wr_no_rd", {30'h0, axi.arvalid, axi.rready}, 32'h0);
            if (!wa_done) begin
               chk("bready_lo", {31'h0, axi.bready}, 32'h0);
               if (!aw_ok) begin
                  chk("awvalid", {31'h0, axi.awvalid}, 32'h1);
                  if (aw_n == 0) begin
                     chk("awaddr", axi.awaddr, word);
                     chk("awlen", {24'h0, axi.awlen}, 32'h0);
                     chk("awsize", {29'h0, axi.awsize}, 32'h2);
                     chk("awburst", {30'h0, axi.awburst}, 32'h1);
                  end
                  if (aw_n >= aw_w) begin
                     axi.awready = 1'b1;
                     aw_ok = 1;
                  end
                  aw_n++;
               end else begin
                  chk("aw_drop", {31'h0, axi.awvalid}, 32'h0);
               end
               if (!w_ok) begin
                  chk("wvalid", {31'h0, axi.wvalid}, 32'h1);
                  if (w_n == 0) begin
                     chk("wdata", axi.wdata, wd);
                     chk("wstrb_wlast", {27'h0, axi.wstrb, axi.wlast},
                         32'h1F);
                  end
                  if (w_n >= w_w) begin
                     axi.wready = 1'b1;
                     w_ok = 1;
                  end
                  w_n++;
               end else begin
                  chk("w_drop", {31'h0, axi.wvalid}, 32'h0);
               end
               wa_done = aw_ok && w_ok;
            end else begin
               chk("aww_drop", {30'h0, axi.awvalid, axi.wvalid}, 32'h0);
               chk("bready", {31'h0, axi.bready}, 32'h1);
               if (d_n >= d_w) begin
                  axi.bvalid = 1'b1;
                  axi.bresp  = resp;
               end
               d_n++;
            end
         end
      end
      if (!done) begin
         chk("timeout", 32'h0, 32'h1);
         mem_req_valid = 1'b0;
         slave_idle();
      end
      @(posedge clk);
      #1;
      slave_idle();
      chk("pulse_once", {31'h0, mem_resp_valid}, 32'h0);
      chk("err_count", {{(32-CW){1'b0}}, err_count}, exp_cnt);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk(tag, {24'h0, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready,
                axi.bready, mem_resp_valid, mem_resp_err, 1'b0}, 32'h0);
      chk({tag, "_data"}, mem_resp_data, 32'h0);
      chk({tag, "_cnt"}, {{(32-CW){1'b0}}, err_count}, 32'h0);
   endtask

   initial begin
      bit op;
      bit kp;
      logic [1:0] rs;
      slave_idle();
      #1;
      chk_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_reset_outputs("post_reset");

      mem[30'h0000_1004 >> 2] = 32'hDEAD_BEEF;
      txn(0, 32'h0000_1006, 32'h0, 0, 0, 0, 0, 2'b00, 1, 0);
      txn(1, 32'h0000_0040, 32'h1234_5678, 0, 2, 0, 0, 2'b00, 1, 0);
      txn(1, 32'h0000_0044, 32'hCAFE_0001, 0, 3, 0, 0, 2'b00, 1, 0);
      txn(1, 32'h0000_0048, 32'hCAFE_0002, 0, 0, 3, 0, 2'b00, 1, 0);
      txn(1, 32'h0000_004C, 32'hCAFE_0003, 0, 2, 2, 1, 2'b00, 1, 0);
      txn(1, 32'h0000_0050, 32'hCAFE_0004, 0, 0, 0, 0, 2'b00, 1, 0);
      txn(0, 32'h0000_0043, 32'h0, 1, 0, 0, 2, 2'b00, 1, 0);

      txn(0, 32'h0000_0080, 32'h0, 0, 0, 0, 0, 2'b10, 1, 0);
      txn(1, 32'h0000_0084, 32'h5555_AAAA, 0, 0, 0, 0, 2'b11, 1, 0);
      txn(0, 32'h0000_0088, 32'h0, 0, 0, 0, 0, 2'b00, 0, 0);
      txn(0, 32'h0000_008C, 32'h0, 0, 0, 0, 0, 2'b10, 1, 0);
      txn(0, 32'h0000_0084, 32'h0, 0, 0, 0, 0, 2'b00, 1, 0);

      txn(0, 32'h0000_0040, 32'h0, 0, 0, 0, 0, 2'b00, 1, 1);
      txn(0, 32'h0000_0044, 32'h0, 2, 0, 0, 1, 2'b00, 1, 1);
      txn(1, 32'h0000_0060, 32'h0BAD_F00D, 0, 1, 0, 0, 2'b00, 1, 0);

      for (int i = 0; i < 40; i++) begin
         op = 1'($urandom_range(0, 1));
         rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3))
                                          : 2'b00;
         kp = (i != 39) && ($urandom_range(0, 2) == 0);
         txn(op, 32'h0000_0100 | ($urandom & 32'h3F), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), rs,
             ($urandom_range(0, 5) != 0), kp);
         if (!kp && $urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
         end
      end

      mem_req_valid = 1'b1;
      mem_req_op    = 1'b0;
      mem_req_addr  = 32'h0000_2008;
      @(posedge clk);
      #1;
      chk("rst_arvalid", {31'h0, axi.arvalid}, 32'h1);
      axi.arready = 1'b1;
      @(posedge clk);
      #1;
      axi.arready = 1'b0;
      chk("rst_rready", {31'h0, axi.rready}, 32'h1);
      #2;
      rst_n = 1'b0;
      mem_req_valid = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      exp_cnt = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_no_pulse", {31'h0, mem_resp_valid}, 32'h0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      txn(0, 32'h0000_2008, 32'h0, 1, 0, 0, 1, 2'b00, 1, 0);
      txn(1, 32'h0000_200C, 32'h7777_8888, 0, 1, 2, 0, 2'b00, 1, 0);
      txn(0, 32'h0000_200C, 32'h0, 0, 0, 0, 0, 2'b00, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
